load_ab_pingpong: RTL

//  Per-PE operand loader for the systolic matrix-multiply array; runtime-configurable successor of the fixed-PID A/B loader.

---
 rtl/load_ab_pkg.sv | 21 ++
 rtl/pp_bank_ram.sv | 23 ++
 rtl/sync_fifo.sv | 44 ++++
 rtl/load_ab_pingpong.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/load_ab_pkg.sv
// Shared types and default sizing for the per-PE ping-pong A/B operand loader.
package load_ab_pkg;
  localparam int D_WIDTH_DEF   = 64;
  localparam int PART_MAX_DEF  = 16;
  localparam int CNT_WIDTH_DEF = 16;
  localparam int PART_W        = $clog2(PART_MAX_DEF);

  typedef enum logic { EMPTY = 1'b0, FULL = 1'b1 } bank_state_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_WAIT_B = 2'd1,
    RD_SWEEP  = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic [D_WIDTH_DEF-1:0] a;
    logic [D_WIDTH_DEF-1:0] b;
    logic                   last;
  } pair_t;
endpackage

// File: rtl/pp_bank_ram.sv
// Two-bank A slice store, addr = {bank, idx}, simple dual port.
// Latency: read data registered, valid the cycle after re.
// Backpressure: none; the caller only reads what it can absorb.
module pp_bank_ram #(
  parameter int D_WIDTH  = 64,
  parameter int PART_MAX = 16,
  parameter int AW       = $clog2(PART_MAX) + 1
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [D_WIDTH-1:0] rdata
);
  logic [D_WIDTH-1:0] mem [2*PART_MAX];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sync_fifo.sv
// Small generic synchronous FIFO; DEPTH must be a power of two.
// Latency: a pushed entry is visible at the output the next cycle.
// Backpressure: the producer watches count; a push into a full FIFO is dropped unless a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic [CW-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             push, pop;

  assign out_vld = (count != '0);
  assign out_dat = mem[rptr];
  assign pop     = out_vld && out_rdy;
  assign push    = in_vld && ((count != CW'(DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= in_dat;
        wptr      <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/load_ab_pingpong.sv
// Per-PE loader: captures this PE's A slice into a ping-pong bank and replays it against every B word.
// Latency: B accepted at t gives the first pair at t+2, then one pair per cycle.
// Backpressure: issue stalls on a full 2-entry output skid; A stalls when the load bank is full.
module load_ab_pingpong
  import load_ab_pkg::*;
#(
  parameter int D_WIDTH   = D_WIDTH_DEF,
  parameter int PART_MAX  = PART_MAX_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [CNT_WIDTH-1:0]        cfg_a_total,
  input  logic [$clog2(PART_MAX):0]   cfg_a_part,
  input  logic [CNT_WIDTH-1:0]        cfg_a_base,
  input  logic [CNT_WIDTH-1:0]        cfg_b_count,
  output logic                        idle,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic [D_WIDTH-1:0]          a_data,
  input  logic                        b_valid,
  output logic                        b_ready,
  input  logic [D_WIDTH-1:0]          b_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [D_WIDTH-1:0]          m_a,
  output logic [D_WIDTH-1:0]          m_b,
  output logic                        m_last
);
  localparam int KW = $clog2(PART_MAX);

  logic                 cfg_ok;
  logic [CNT_WIDTH-1:0] a_total_q, a_base_q, b_count_q;
  logic [KW:0]          part_q, part_in;

  bank_state_t          bank_st [2];
  logic                 load_sel, rd_bank, rd_full, swap, release_bank;
  logic [CNT_WIDTH-1:0] a_idx;
  logic                 a_hs, a_own, a_last;

  rd_state_t            state, state_nxt;
  logic [KW-1:0]        k_q, cur_k;
  logic [CNT_WIDTH-1:0] b_cnt;
  logic                 start, issue, k_last, b_last, space, pop;
  logic [D_WIDTH-1:0]   b_hold, ram_rdata, pend_b;
  logic                 pend, pend_last;
  logic [2:0]           occ;

  pair_t                fifo_in, fifo_out;
  logic [1:0]           fifo_cnt;

  // Out-of-range slice lengths mean "use the whole bank".
  assign part_in = (cfg_a_part == '0 || cfg_a_part > (KW+1)'(PART_MAX)) ? (KW+1)'(PART_MAX) : cfg_a_part;

  assign idle = (bank_st[0] == EMPTY) && (bank_st[1] == EMPTY) && (a_idx == '0) && !pend && (fifo_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ok    <= 1'b0;
      a_total_q <= '0;
      a_base_q  <= '0;
      b_count_q <= '0;
      part_q    <= '0;
    end else if (cfg_we && idle) begin
      cfg_ok    <= 1'b1;
      a_total_q <= cfg_a_total;
      a_base_q  <= cfg_a_base;
      b_count_q <= cfg_b_count;
      part_q    <= part_in;
    end
  end

  assign rd_bank = ~load_sel;
  assign rd_full = (bank_st[rd_bank] == FULL);
  assign a_ready = cfg_ok && (bank_st[load_sel] == EMPTY);
  assign a_hs    = a_valid && a_ready;
  assign a_own   = (a_idx >= a_base_q) &&
                   ({1'b0, a_idx} < {1'b0, a_base_q} + (CNT_WIDTH+1)'(part_q));
  assign a_last  = (a_idx == a_total_q - CNT_WIDTH'(1));
  assign swap    = (bank_st[load_sel] == FULL) && !rd_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      load_sel   <= 1'b0;
      a_idx      <= '0;
    end else begin
      if (a_hs) begin
        if (a_last) begin
          a_idx             <= '0;
          bank_st[load_sel] <= FULL;
        end else begin
          a_idx <= a_idx + CNT_WIDTH'(1);
        end
      end
      if (release_bank) bank_st[rd_bank] <= EMPTY;
      if (swap) load_sel <= ~load_sel;
    end
  end

  // Pairs already committed (skid + RAM read in flight) must leave room for one more.
  assign pop   = m_valid && m_ready;
  assign occ   = {1'b0, fifo_cnt} + {2'b0, pend} - {2'b0, pop};
  assign space = (occ < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) state <= RD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (issue) begin
      if (!k_last)     state_nxt = RD_SWEEP;
      else if (b_last) state_nxt = RD_IDLE;
      else             state_nxt = RD_WAIT_B;
    end else if (state == RD_IDLE && rd_full) begin
      state_nxt = RD_WAIT_B;
    end
  end

  always_comb begin
    cur_k        = (state == RD_SWEEP) ? k_q : '0;
    start        = (state != RD_SWEEP) && rd_full && b_valid && space;
    issue        = start || ((state == RD_SWEEP) && space);
    k_last       = ((KW+1)'(cur_k) == part_q - (KW+1)'(1));
    b_last       = (b_cnt == b_count_q - CNT_WIDTH'(1));
    release_bank = issue && k_last && b_last;
    b_ready      = start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q       <= '0;
      b_cnt     <= '0;
      b_hold    <= '0;
      pend      <= 1'b0;
      pend_b    <= '0;
      pend_last <= 1'b0;
    end else begin
      pend <= issue;
      if (start) b_hold <= b_data;
      if (issue) begin
        pend_b    <= start ? b_data : b_hold;
        pend_last <= release_bank;
        if (k_last) begin
          k_q   <= '0;
          b_cnt <= b_last ? '0 : b_cnt + CNT_WIDTH'(1);
        end else begin
          k_q <= cur_k + KW'(1);
        end
      end
    end
  end

  pp_bank_ram #(.D_WIDTH(D_WIDTH), .PART_MAX(PART_MAX)) u_ram (
    .clk   (clk),
    .we    (a_hs && a_own),
    .waddr ({load_sel, KW'(a_idx - a_base_q)}),
    .wdata (a_data),
    .re    (issue),
    .raddr ({rd_bank, cur_k}),
    .rdata (ram_rdata)
  );

  assign fifo_in = '{a: ram_rdata, b: pend_b, last: pend_last};

  sync_fifo #(.WIDTH($bits(pair_t)), .DEPTH(2)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (pend),
    .in_dat  (fifo_in),
    .out_vld (m_valid),
    .out_rdy (m_ready),
    .out_dat (fifo_out),
    .count   (fifo_cnt)
  );

  assign m_a    = fifo_out.a;
  assign m_b    = fifo_out.b;
  assign m_last = fifo_out.last;
endmodule
